// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned INSTR_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHalt
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush overrides push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            push_i,
   input  fetch_entry_t    push_data_i,
   input  logic            pop_i,
   output fetch_entry_t    head_o,
   output logic [CntW-1:0] count_o
);

   fetch_entry_t    mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (push_i && !pop_i) begin
         count_d = count_q + 1'b1;
      end else if (pop_i && !push_i) begin
         count_d = count_q - 1'b1;
      end
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_i) begin
               mem_q[wr_ptr_q] <= push_data_i;
               wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
         end
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: ROM sequencing, prefetch queue, redirect and halt handling.
// Optional same-cycle queue bypass is enabled by defining FETCH_BYPASS_EN.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned      QDEPTH  = 4,
   parameter logic [ADDR_W-1:0] ResetPc = RESET_PC,
   localparam int unsigned     CntW    = $clog2(QDEPTH) + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   output logic [ADDR_W-1:0]  imem_pc_o,
   output logic               imem_en_o,
   input  logic [INSTR_W-1:0] imem_instr_i,
   output logic               dec_valid_o,
   input  logic               dec_ready_i,
   output logic [INSTR_W-1:0] dec_instr_o,
   output logic [ADDR_W-1:0]  dec_pc_o,
   input  logic               redir_valid_i,
   input  logic [ADDR_W-1:0]  redir_pc_i,
   input  logic               halt_req_i,
   output logic [CntW-1:0]    q_count_o
);

   localparam logic [CntW-1:0] DepthCnt = CntW'(QDEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] imem_pc_q, imem_pc_d;
   fetch_entry_t      hold_q, hold_d;

   fetch_entry_t    head, src, shown;
   logic [CntW-1:0] count;
   logic            redir, run_ok, q_empty, byp, src_valid;
   logic            pop, fetch, q_push, q_pop;

   fetch_queue #(
      .Depth (QDEPTH)
   ) u_queue (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (redir),
      .push_i      (q_push),
      .push_data_i ('{pc: fetch_pc_q, instr: imem_instr_i}),
      .pop_i       (q_pop),
      .head_o      (head),
      .count_o     (count)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect outranks halt: state is held in a redirect cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  state_d = halt_req_i ? StHalt : StRun;
         StRun:   if (!redir_valid_i && halt_req_i) state_d = StHalt;
         StHalt:  if (!redir_valid_i && !halt_req_i) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      redir   = redir_valid_i && (state_q != StIdle);
      run_ok  = (state_q == StRun) && !redir && !halt_req_i;
      q_empty = (count == '0);
      byp     = 1'b0;
      src     = head;
`ifdef FETCH_BYPASS_EN
      byp = q_empty && run_ok;
      if (q_empty) begin
         src = '{pc: fetch_pc_q, instr: imem_instr_i};
      end
`endif
      src_valid   = !q_empty || byp;
      shown       = src_valid ? src : hold_q;
      dec_valid_o = src_valid && !redir;
      dec_pc_o    = shown.pc;
      dec_instr_o = shown.instr;
      pop         = dec_valid_o && dec_ready_i;
      fetch       = run_ok && ((count < DepthCnt) || pop);
      q_pop       = pop && !byp;
      // A bypassed word accepted by decode is never enqueued.
      q_push      = fetch && !(byp && pop);
      imem_en_o   = fetch;
      imem_pc_o   = fetch ? fetch_pc_q : imem_pc_q;
      q_count_o   = count;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      imem_pc_d  = imem_pc_q;
      hold_d     = hold_q;
      if (redir) begin
         fetch_pc_d = redir_pc_i;
      end else if (fetch) begin
         fetch_pc_d = fetch_pc_q + 1'b1;
         imem_pc_d  = fetch_pc_q;
      end
      if (dec_valid_o) begin
         hold_d = shown;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q <= ResetPc;
         imem_pc_q  <= ResetPc;
         hold_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         imem_pc_q  <= imem_pc_d;
         hold_q     <= hold_d;
      end
   end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller sequencing the 16-bit word-addressed instruction ROM for the 6-stage RISC pipeline. Generates the ROM address and enable each cycle, captures returned instruction words with their PCs into a small prefetch queue, and hands them to decode over a valid/ready handshake. Handles branch/jump redirects (flush and re-steer) and a halt request that stops fetching while the queue drains.

## Interface
- ADDR_W, 16, PC/ROM address width (word address)
- INSTR_W, 16, instruction width
- QDEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first PC fetched after reset

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_pc  out  ADDR_W  ROM address
- imem_en  out  1  ROM enable; ROM returns instruction combinationally in the same cycle
- imem_instr  in  INSTR_W  ROM data
- dec_valid  out  1  head entry valid
- dec_ready  in  1  decode accepts head entry
- dec_instr  out  INSTR_W  head instruction
- dec_pc  out  ADDR_W  head PC
- redir_valid  in  1  redirect pulse from branch/jump resolution or predictor
- redir_pc  in  ADDR_W  redirect target
- halt_req  in  1  level; stop issuing fetches
- q_count  out  $clog2(QDEPTH)+1  queue occupancy

## Operation
- States: IDLE, RUN, HALT.
- IDLE: entered on reset; exactly one cycle after rst_n deasserts, then RUN (or HALT if halt_req=1). No fetch in IDLE.
- RUN: fetch issued when q_count<QDEPTH or a pop occurs the same cycle. Fetch = imem_en=1, imem_pc=fetch_pc; {fetch_pc, imem_instr} pushed; fetch_pc<=fetch_pc+1, wrapping 16'hFFFF→16'h0000.
- No fetch → imem_en=0, imem_pc holds last value.
- Pop: dec_valid && dec_ready.
- Redirect (redir_valid=1), any state except IDLE: queue flushed, fetch_pc<=redir_pc, no fetch and no pop that cycle, dec_valid forced 0. Next cycle fetches redir_pc (if RUN).
- halt_req=1 in RUN → HALT next cycle; no fetches; queue keeps draining to decode. halt_req=0 in HALT → RUN next cycle, resuming at fetch_pc. Redirect in HALT updates fetch_pc and flushes, stays HALT.
- Precedence per cycle: reset > redirect > halt > fetch/pop.
- Full queue with dec_ready=1: simultaneous pop and push, count unchanged.
- Empty queue, no fetch: dec_valid=0; dec_instr/dec_pc hold last values.

## Timing
- Reset values: imem_en=0, imem_pc=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, q_count=0, state IDLE, fetch_pc=RESET_PC.
- Fetch latency (default): word fetched in cycle N visible at decode in cycle N+1 (registered queue output).
- Redirect penalty: redirect in cycle N, target instruction at decode in cycle N+2.
- dec_instr/dec_pc stable while dec_valid=1 and dec_ready=0.
- Sustained throughput: one instruction per cycle with dec_ready held high.
- Reset assertion mid-operation: all state and outputs return to reset values immediately (asynchronous); in-flight queue contents discarded.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and a fetch occurs, the word drives dec_valid/dec_instr/dec_pc combinationally in the same cycle; if accepted it is not enqueued. Fetch-to-decode latency 0, redirect penalty 1 cycle.
- Not defined: all words pass through the queue; latencies as in Timing.

## Structure
- Package fetch_pkg: ADDR_W/INSTR_W defaults, RESET_PC, fetch state enum (IDLE, RUN, HALT), queue-entry struct {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO of QDEPTH entries with push, pop, flush, count; flush overrides push/pop.
- Top: state machine, fetch_pc register, bypass mux.

## Test plan
- Reset release, dec_ready=1 → imem_pc 0,1,2,…; dec_pc 0,1,2,… from cycle 2 after release, one per cycle, dec_instr equals ROM contents.
- dec_ready=0 for 8 cycles → exactly QDEPTH fetches, imem_en low afterwards, q_count=4; dec_ready=1 → PCs continue without gaps or duplicates.
- Redirect to 16'h0005 while queue holds PCs 3–6 → next accepted dec_pc is 5, no stale PCs delivered; same-cycle dec_ready handshake suppressed.
- halt_req high with 3 queued → 3 entries delivered, imem_en=0, dec_valid falls; halt_req low → fetch resumes at next sequential PC.
- fetch_pc forced to 16'hFFFE via redirect → dec_pc sequence FFFE, FFFF, 0000, 0001.
- rst_n pulsed low mid-stream with full queue → outputs at reset values same cycle; after release fetch restarts at RESET_PC.
